// File: rtl/ex_result_stage.sv
// ex_result_stage: two-entry elastic buffer behind the ALU.
// Holds ALU results with writeback/store metadata, owns the NZCV flag
// register, and offers a combinational forwarding lookup into buffered
// entries. The forwarding lookup is built only when EX_RESULT_FWD_EN is
// defined; otherwise fwd_hit/fwd_data are tied to zero.
module ex_result_stage #(
    parameter int DATA_W = 19,
    parameter int REG_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [3:0]        in_flags,
    input  logic              in_set_flags,
    input  logic [REG_W-1:0]  in_rd,
    input  logic              in_reg_we,
    input  logic              in_mem_we,
    input  logic [DATA_W-1:0] in_store_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_reg_we,
    output logic              out_mem_we,
    output logic [DATA_W-1:0] out_store_data,
    output logic [3:0]        flags,
    input  logic              flush,
    input  logic [REG_W-1:0]  fwd_rd,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;

    // Slot 0 is always the head (oldest); slot 1 is only valid in FULL.
    logic [DATA_W-1:0] res_q [2];
    logic [REG_W-1:0]  rd_q  [2];
    logic              rwe_q [2];
    logic              mwe_q [2];
    logic [DATA_W-1:0] sd_q  [2];

    logic push;
    logic pop;

    // Handshake decode depends on state only.
    always_comb begin
        in_ready  = (state != FULL);
        out_valid = (state != EMPTY);
        push      = in_valid & in_ready & ~flush;
        pop       = out_valid & out_ready & ~flush;
    end

    // FIFO occupancy FSM and entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            for (int unsigned i = 0; i < 2; i++) begin
                res_q[i] <= '0;
                rd_q[i]  <= '0;
                rwe_q[i] <= 1'b0;
                mwe_q[i] <= 1'b0;
                sd_q[i]  <= '0;
            end
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        res_q[0] <= in_result;
                        rd_q[0]  <= in_rd;
                        rwe_q[0] <= in_reg_we;
                        mwe_q[0] <= in_mem_we;
                        sd_q[0]  <= in_store_data;
                        state    <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        // Old head leaves, new entry takes the head slot.
                        res_q[0] <= in_result;
                        rd_q[0]  <= in_rd;
                        rwe_q[0] <= in_reg_we;
                        mwe_q[0] <= in_mem_we;
                        sd_q[0]  <= in_store_data;
                    end else if (push) begin
                        res_q[1] <= in_result;
                        rd_q[1]  <= in_rd;
                        rwe_q[1] <= in_reg_we;
                        mwe_q[1] <= in_mem_we;
                        sd_q[1]  <= in_store_data;
                        state    <= FULL;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        res_q[0] <= res_q[1];
                        rd_q[0]  <= rd_q[1];
                        rwe_q[0] <= rwe_q[1];
                        mwe_q[0] <= mwe_q[1];
                        sd_q[0]  <= sd_q[1];
                        state    <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // Architectural flag register, updated only by accepted flag-setting entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags <= 4'b0000;
        end else if (push && in_set_flags) begin
            flags <= in_flags;
        end
    end

    // Head fields, forced to zero while empty.
    always_comb begin
        out_result     = out_valid ? res_q[0] : '0;
        out_rd         = out_valid ? rd_q[0]  : '0;
        out_reg_we     = out_valid & rwe_q[0];
        out_mem_we     = out_valid & mwe_q[0];
        out_store_data = out_valid ? sd_q[0]  : '0;
    end

`ifdef EX_RESULT_FWD_EN
    // Forwarding lookup, youngest valid entry first.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (state == FULL && rwe_q[1] && rd_q[1] == fwd_rd) begin
            fwd_hit  = 1'b1;
            fwd_data = res_q[1];
        end else if (state != EMPTY && rwe_q[0] && rd_q[0] == fwd_rd) begin
            fwd_hit  = 1'b1;
            fwd_data = res_q[0];
        end
    end
`else
    logic unused_fwd_rd;

    // Forwarding not built: outputs tied off.
    always_comb begin
        unused_fwd_rd = ^fwd_rd;
        fwd_hit       = 1'b0;
        fwd_data      = '0;
    end
`endif

endmodule

// File: doc/ex_result_stage.md
# ex_result_stage

Two-entry elastic pipeline stage directly downstream of the 19-bit ALU. It captures the ALU result and its N/Z/C/V flags together with the instruction's writeback and store metadata, and holds the architectural condition-flag register. It decouples the execute stage from a stalling memory/writeback stage through a valid/ready handshake, and optionally forwards buffered results back to operand selection.

## Interface
- DATA_W, 19, datapath width; matches ALU Result.
- REG_W, 4, destination register index width.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept this cycle.
- in_result  in  DATA_W  ALU Result.
- in_flags  in  4  {Negative, Zero, Carry, OverFlow} from the ALU, bit 3 = N.
- in_set_flags  in  1  instruction updates the flag register.
- in_rd  in  REG_W  destination register.
- in_reg_we  in  1  instruction writes a register.
- in_mem_we  in  1  instruction is a store.
- in_store_data  in  DATA_W  store data.
- out_valid  out  1  head entry present.
- out_ready  in  1  downstream accepts head.
- out_result, out_rd, out_reg_we, out_mem_we, out_store_data  out  DATA_W/REG_W/1/1/DATA_W  head entry fields.
- flags  out  4  architectural NZCV register.
- flush  in  1  discard all buffered entries.
- fwd_rd  in  REG_W  register being looked up by operand select.
- fwd_hit  out  1  a buffered entry will write fwd_rd.
- fwd_data  out  DATA_W  result of the matching entry.

## Operation
- Storage: 2-entry in-order FIFO; FSM states EMPTY, ONE, FULL.
- push = in_valid & in_ready & ~flush; pop = out_valid & out_ready & ~flush.
- in_ready = (state != FULL), driven purely from state (no combinational path from out_ready).
- out_valid = (state != EMPTY); out_* show the oldest entry. When EMPTY, out_* fields read 0.
- Transitions: EMPTY→ONE on push. ONE→FULL on push without pop. ONE→EMPTY on pop without push. ONE→ONE on simultaneous push and pop; the new entry becomes head. FULL→ONE on pop; push is impossible when FULL.
- flush: the state goes to EMPTY next edge regardless of push/pop. A same-cycle push is dropped and does not update flags.
- Flags: on push with in_set_flags=1, flags <= in_flags at that edge. Flags are never changed by pop or flush and are otherwise held.
- Forwarding lookup is combinational. Search valid entries youngest-first for reg_we=1 and rd==fwd_rd. The first match sets fwd_hit=1 and fwd_data to its result. No match gives fwd_hit=0 and fwd_data=0.
- Fields are passed through unmodified. No arithmetic is performed on the data.

## Timing
- Reset (rst_n=0, asynchronous) sets state to EMPTY, both entries to 0, and flags to 4'b0000.
- Outputs during and after reset: out_valid=0, in_ready=1, all out_* fields 0, fwd_hit=0, fwd_data=0.
- Reset mid-operation: buffered entries are lost immediately, without waiting for an edge.
- Latency: an entry pushed at edge k has out_valid=1 from edge k onward when the FIFO was empty. Flags are visible from edge k.
- Throughput: 1 entry/cycle while out_ready stays high.
- A held head (out_ready=0) keeps all out_* fields stable until popped.
- The forward path reflects state after the last edge. An entry in flight on the in_* ports is not forwarded.

## Configuration
- EX_RESULT_FWD_EN defined: forwarding lookup is implemented as described.
- EX_RESULT_FWD_EN undefined: the fwd_* ports remain present. fwd_hit and fwd_data are tied to 0 and the lookup logic is not built.

## Test plan
- Reset, then push result=19'h00005, rd=3, reg_we=1 with out_ready=1. Required: out_valid=1 next cycle with out_result=5, out_rd=3; FIFO EMPTY the cycle after.
- Push A=1, B=2, C=3 back-to-back with out_ready=0. Required: A and B accepted; in_ready=0 after the second push; C held. Raise out_ready: outputs come out in order 1, 2, 3 and the third push is accepted when in_ready returns to 1.
- Push in_flags=4'b0100 with set_flags=1, then 4'b1000 with set_flags=0. Required: flags=4'b0100 and stays 4'b0100.
- FULL with entries rd=5 (result 7, older) and rd=5 (result 9, younger), fwd_rd=5. Required: fwd_hit=1 and fwd_data=9 (with the macro), fwd_hit=0 (without it).
- FULL, assert flush together with in_valid=1 and in_set_flags=1, in_flags=4'b0001. Required: EMPTY next cycle, out_valid=0, flags unchanged.
- Assert rst_n=0 mid-cycle while ONE. Required: out_valid=0 and flags=0 immediately, before the next clock edge.
